// File: rtl/if_fetch_unit.sv
// IF stage: program counter, next-PC selection and instruction-memory handshake.
// Loads the IF/ID register and honours hazard-unit stall and redirects.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] pc_out,
  input  logic [31:0] adder_sum,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold, StDrain} state_e;

  state_e      stateQ, stateD;
  logic [31:0] pcQ, pcD;
  logic [31:0] holdBufQ, holdBufD;
  logic [31:0] redirPcQ, redirPcD;
  logic [31:0] instrQ, instrD;
  logic [31:0] pc4Q, pc4D;
  logic        validQ, validD;

  logic        redirect;
  logic [31:0] rawTarget;
  logic [31:0] target;

  // Priority: exception > branch > jump; targets are always word aligned.
  always_comb begin
    redirect = exception | branch_taken | jump;
    if (exception) begin
      rawTarget = EXC_VECTOR;
    end else if (branch_taken) begin
      rawTarget = branch_target;
    end else begin
      rawTarget = jump_target;
    end
    target = rawTarget & 32'hFFFF_FFFC;
  end

  always_comb begin
    stateD   = stateQ;
    pcD      = pcQ;
    holdBufD = holdBufQ;
    redirPcD = redirPcQ;
    instrD   = instrQ;
    pc4D     = pc4Q;
    validD   = validQ;
    unique case (stateQ)
      StBoot: begin
        stateD = StFetch;
      end
      StFetch: begin
        if (redirect) begin
          validD = 1'b0;
          if (imem_ready) begin
            pcD = target;
          end else begin
            redirPcD = target;
            stateD   = StDrain;
          end
        end else if (imem_ready) begin
          if (stall) begin
            holdBufD = imem_rdata;
            stateD   = StHold;
          end else begin
            instrD = imem_rdata;
            pc4D   = adder_sum;
            validD = 1'b1;
            pcD    = adder_sum;
          end
        end else if (!stall) begin
          validD = 1'b0;
        end
      end
      StHold: begin
        if (redirect) begin
          pcD    = target;
          validD = 1'b0;
          stateD = StFetch;
        end else if (!stall) begin
          instrD = holdBufQ;
          pc4D   = adder_sum;
          validD = 1'b1;
          pcD    = adder_sum;
          stateD = StFetch;
        end
      end
      StDrain: begin
        // The in-flight read must complete before the redirect takes effect.
        validD = 1'b0;
        if (imem_ready) begin
          pcD    = redirect ? target : redirPcQ;
          stateD = StFetch;
        end else if (redirect) begin
          redirPcD = target;
        end
      end
      default: begin
        stateD = StBoot;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ   <= StBoot;
      pcQ      <= RESET_PC;
      holdBufQ <= 32'h0;
      redirPcQ <= 32'h0;
      instrQ   <= 32'h0;
      pc4Q     <= 32'h0;
      validQ   <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pcQ      <= pcD;
      holdBufQ <= holdBufD;
      redirPcQ <= redirPcD;
      instrQ   <= instrD;
      pc4Q     <= pc4D;
      validQ   <= validD;
    end
  end

  assign pc_out        = pcQ;
  assign imem_addr     = pcQ;
  assign imem_req      = (stateQ == StFetch) || (stateQ == StDrain);
  assign ifid_instr    = instrQ;
  assign ifid_pc_plus4 = pc4Q;
  assign ifid_valid    = validQ;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a behavioural fetch model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_if_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] ExcVec  = 32'h8000_0180;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_out, adder_sum;
  logic        stall = 1'b0, exception = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = 32'h0, jump_target = 32'h0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_instr, ifid_pc_plus4;
  logic        ifid_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clock(clock), .reset(reset), .pc_out(pc_out), .adder_sum(adder_sum),
    .stall(stall), .exception(exception), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0040_0010) return 32'h2408_0005;
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // External PCAdder and instruction memory.
  assign adder_sum  = pc_out + 32'd4;
  assign imem_rdata = memWord(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the fetch stage is waiting on, in spec terms.
  logic [31:0] mPc, mParkWord, mRedirAddr, mInstr, mPc4;
  logic        mBoot, mPark, mRedir, mValid;
  wire         anyRedir = exception | branch_taken | jump;
  wire  [31:0] tgt = (exception ? ExcVec : branch_taken ? branch_target : jump_target)
                     & 32'hFFFF_FFFC;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mPc <= ResetPc; mBoot <= 1'b1; mPark <= 1'b0; mRedir <= 1'b0;
      mValid <= 1'b0; mInstr <= 32'h0; mPc4 <= 32'h0; mParkWord <= 32'h0; mRedirAddr <= 32'h0;
    end else if (mBoot) begin
      mBoot <= 1'b0;
    end else if (mRedir) begin
      mValid <= 1'b0;
      if (imem_ready) begin
        mPc <= anyRedir ? tgt : mRedirAddr;
        mRedir <= 1'b0;
      end else if (anyRedir) begin
        mRedirAddr <= tgt;
      end
    end else if (mPark) begin
      if (anyRedir) begin
        mPc <= tgt; mValid <= 1'b0; mPark <= 1'b0;
      end else if (!stall) begin
        mInstr <= mParkWord; mPc4 <= mPc + 32'd4; mValid <= 1'b1; mPc <= mPc + 32'd4;
        mPark <= 1'b0;
      end
    end else if (anyRedir) begin
      mValid <= 1'b0;
      if (imem_ready) mPc <= tgt;
      else begin
        mRedir <= 1'b1; mRedirAddr <= tgt;
      end
    end else if (imem_ready) begin
      if (stall) begin
        mPark <= 1'b1; mParkWord <= memWord(mPc);
      end else begin
        mInstr <= memWord(mPc); mPc4 <= mPc + 32'd4; mValid <= 1'b1; mPc <= mPc + 32'd4;
      end
    end else if (!stall) begin
      mValid <= 1'b0;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clock) begin
    chk("pc", pc_out, mPc);
    chk("imem_addr", imem_addr, mPc);
    chk("imem_req", {31'b0, imem_req}, {31'b0, !mBoot && !mPark});
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, mValid});
    if (mValid) begin
      chk("ifid_instr", ifid_instr, mInstr);
      chk("ifid_pc_plus4", ifid_pc_plus4, mPc4);
    end
  end

  task automatic cyc(input logic rdy, input logic stl, input logic exc, input logic br,
                     input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    imem_ready = rdy; stall = stl; exception = exc; branch_taken = br;
    branch_target = bt; jump = jp; jump_target = jt;
    @(negedge clock);
    #1;
  endtask

  task automatic plain(input logic rdy, input logic stl);
    cyc(rdy, stl, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("reset_pc", pc_out, ResetPc);
    chk("reset_req", {31'b0, imem_req}, 32'h0);
    chk("reset_valid", {31'b0, ifid_valid}, 32'h0);
    chk("reset_instr", ifid_instr, 32'h0);
    chk("reset_pc4", ifid_pc_plus4, 32'h0);
    reset = 1'b1;
    plain(1'b1, 1'b0);                       // boot edge
    chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
    chk("boot_req", {31'b0, imem_req}, 32'h1);

    // Zero-wait streaming
    plain(1'b1, 1'b0);
    chk("t1_pc4_0", ifid_pc_plus4, 32'h0040_0004);
    chk("t1_valid_0", {31'b0, ifid_valid}, 32'h1);
    chk("t1_addr_0", imem_addr, 32'h0040_0004);
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    chk("t1_pc4_2", ifid_pc_plus4, 32'h0040_000C);

    // Two wait states
    plain(1'b0, 1'b0);
    chk("t2_addr_w1", imem_addr, 32'h0040_000C);
    chk("t2_valid_w1", {31'b0, ifid_valid}, 32'h0);
    plain(1'b0, 1'b0);
    chk("t2_addr_w2", imem_addr, 32'h0040_000C);
    plain(1'b1, 1'b0);
    chk("t2_valid", {31'b0, ifid_valid}, 32'h1);
    chk("t2_pc4", ifid_pc_plus4, 32'h0040_0010);

    // Stall on the ready cycle, three cycles
    plain(1'b1, 1'b1);
    chk("t3_req_hold", {31'b0, imem_req}, 32'h0);
    chk("t3_pc4_frozen", ifid_pc_plus4, 32'h0040_0010);
    plain(1'b1, 1'b1);
    plain(1'b1, 1'b1);
    chk("t3_pc_hold", pc_out, 32'h0040_0010);
    plain(1'b0, 1'b0);
    chk("t3_word", ifid_instr, 32'h2408_0005);
    chk("t3_pc", pc_out, 32'h0040_0014);
    plain(1'b0, 1'b0);
    chk("t3_once", {31'b0, ifid_valid}, 32'h0);

    // Branch while memory is busy
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    chk("t4_drain_req", {31'b0, imem_req}, 32'h1);
    chk("t4_drain_addr", imem_addr, 32'h0040_0014);
    plain(1'b0, 1'b0);
    chk("t4_valid", {31'b0, ifid_valid}, 32'h0);
    plain(1'b1, 1'b0);
    chk("t4_addr", imem_addr, 32'h0040_0100);
    chk("t4_valid_end", {31'b0, ifid_valid}, 32'h0);

    // Latest redirect wins in drain, including a same-cycle one
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0300);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0304);
    plain(1'b1, 1'b0);
    chk("drain_latest", pc_out, 32'h0040_0304);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0400);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0500, 1'b0, 32'h0);
    chk("drain_same_cycle", pc_out, 32'h0040_0500);

    // Priority and alignment
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0800, 1'b1, 32'h0040_0900);
    chk("t5_exc", pc_out, 32'h8000_0180);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0102, 1'b1, 32'h0040_0900);
    chk("t5_align", pc_out, 32'h0040_0100);

    // Redirect out of HOLD drops the parked word
    plain(1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
    chk("hold_redir_pc", pc_out, 32'h0040_0040);
    chk("hold_redir_req", {31'b0, imem_req}, 32'h1);
    plain(1'b1, 1'b0);
    chk("hold_redir_next", ifid_pc_plus4, 32'h0040_0044);

    // Wrap, then async reset in the middle of a drain
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    chk("t6_top", pc_out, 32'hFFFF_FFFC);
    plain(1'b1, 1'b0);
    chk("t6_wrap_pc", pc_out, 32'h0000_0000);
    chk("t6_wrap_pc4", ifid_pc_plus4, 32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_pc", pc_out, ResetPc);
    chk("t6_rst_req", {31'b0, imem_req}, 32'h0);
    chk("t6_rst_valid", {31'b0, ifid_valid}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    plain(1'b1, 1'b0);
    plain(1'b1, 1'b0);
    chk("t6_restart", ifid_pc_plus4, 32'h0040_0004);
    chk("t6_restart_valid", {31'b0, ifid_valid}, 32'h1);

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
